// File: rtl/tod_pkg.sv
// Shared widths, default terminal values and FSM state encoding for the
// time-of-day counter.
package tod_pkg;

    localparam int unsigned MIN_W        = 6;
    localparam int unsigned HOUR_W       = 5;
    localparam int unsigned MIN_MAX_DEF  = 59;
    localparam int unsigned HOUR_MAX_DEF = 23;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : tod_pkg

// File: rtl/wrap_counter.sv
// Compare-and-wrap up counter with synchronous load; wrap is the
// combinational "at terminal value and incrementing" flag.
module wrap_counter #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign wrap = inc && (value_q == MAX_V);

    // NOTE: every branch assigns value_d (default first), so no latch is inferred.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (wrap) begin
            value_d = '0;
        end else if (inc) begin
            value_d = value_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : wrap_counter

// File: rtl/time_of_day_counter.sv
// 24-hour minutes/hours counter with a host time-set handshake and registered
// rollover pulses. Optional alarm compare is enabled by defining TOD_ALARM_EN.
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter int unsigned MIN_MAX  = MIN_MAX_DEF,
    parameter int unsigned HOUR_MAX = HOUR_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              min_tick,
    input  logic              set_valid,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    output logic              set_ready,
    output logic              set_done,
    output logic              set_err,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
`ifdef TOD_ALARM_EN
    input  logic              alarm_wr,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    input  logic              alarm_arm,
    output logic              alarm_hit,
`endif
    output logic              hour_rollover,
    output logic              day_rollover
);

    localparam logic [MIN_W-1:0]  MIN_MAX_V  = MIN_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_MAX_V = HOUR_W'(HOUR_MAX);

    state_e            state_q, state_d;
    logic [MIN_W-1:0]  stage_min_q;
    logic [HOUR_W-1:0] stage_hr_q;
    logic              set_ready_q, set_done_q, set_err_q;
    logic              hour_roll_q, day_roll_q;

    logic accept, tick_run, in_range, load_ok, min_wrap, hour_wrap;

    // Ticks only count in RUN when no request is being accepted that cycle.
    assign accept   = (state_q == RUN) && set_valid;
    assign tick_run = (state_q == RUN) && !set_valid && min_tick;
    assign in_range = (stage_min_q <= MIN_MAX_V) && (stage_hr_q <= HOUR_MAX_V);
    assign load_ok  = (state_q == LOAD) && in_range;

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_minutes (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (tick_run),
        .load     (load_ok),
        .load_val (stage_min_q),
        .value    (minutes),
        .wrap     (min_wrap)
    );

    wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hours (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (min_wrap),
        .load     (load_ok),
        .load_val (stage_hr_q),
        .value    (hours),
        .wrap     (hour_wrap)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (set_valid) state_d = LOAD;
            LOAD:    state_d = DONE;
            DONE:    if (!set_valid) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stage_min_q <= '0;
            stage_hr_q  <= '0;
            set_ready_q <= 1'b1;
            set_done_q  <= 1'b0;
            set_err_q   <= 1'b0;
            hour_roll_q <= 1'b0;
            day_roll_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_ready_q <= (state_d == RUN);
            set_done_q  <= load_ok;
            set_err_q   <= (state_q == LOAD) && !in_range;
            hour_roll_q <= min_wrap;
            day_roll_q  <= hour_wrap;
            if (accept) begin
                stage_min_q <= set_minutes;
                stage_hr_q  <= set_hours;
            end
        end
    end

    assign set_ready     = set_ready_q;
    assign set_done      = set_done_q;
    assign set_err       = set_err_q;
    assign hour_rollover = hour_roll_q;
    assign day_rollover  = day_roll_q;

`ifdef TOD_ALARM_EN
    logic [MIN_W-1:0]  alarm_min_q;
    logic [HOUR_W-1:0] alarm_hr_q;
    logic              alarm_hit_q;
    logic [MIN_W-1:0]  min_next;
    logic [HOUR_W-1:0] hr_next;

    // Value the counters take on this edge when a tick is counted.
    always_comb begin
        min_next = min_wrap ? '0 : minutes + MIN_W'(1);
        hr_next  = hours;
        if (hour_wrap) begin
            hr_next = '0;
        end else if (min_wrap) begin
            hr_next = hours + HOUR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_min_q <= '0;
            alarm_hr_q  <= '0;
            alarm_hit_q <= 1'b0;
        end else begin
            if (alarm_wr) begin
                alarm_min_q <= alarm_minutes;
                alarm_hr_q  <= alarm_hours;
            end
            alarm_hit_q <= alarm_arm && tick_run &&
                           (min_next == alarm_min_q) && (hr_next == alarm_hr_q);
        end
    end

    assign alarm_hit = alarm_hit_q;
`endif

endmodule : time_of_day_counter

// File: tb/tb_time_of_day_counter.sv
// Directed self-checking bench for time_of_day_counter; alarm scenario runs
// only when TOD_ALARM_EN is defined.
module tb_time_of_day_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       min_tick = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic       set_ready, set_done, set_err;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       hour_rollover, day_rollover;
`ifdef TOD_ALARM_EN
    logic       alarm_wr = 1'b0;
    logic [4:0] alarm_hours = '0;
    logic [5:0] alarm_minutes = '0;
    logic       alarm_arm = 1'b0;
    logic       alarm_hit;
`endif

    int errors = 0;
    int checks = 0;

    // Pulse tallies sampled on the falling edge, away from the active edge.
    int hr_cnt = 0, day_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, alarm_cnt = 0;

    time_of_day_counter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .min_tick      (min_tick),
        .set_valid     (set_valid),
        .set_hours     (set_hours),
        .set_minutes   (set_minutes),
        .set_ready     (set_ready),
        .set_done      (set_done),
        .set_err       (set_err),
        .minutes       (minutes),
        .hours         (hours),
`ifdef TOD_ALARM_EN
        .alarm_wr      (alarm_wr),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .alarm_arm     (alarm_arm),
        .alarm_hit     (alarm_hit),
`endif
        .hour_rollover (hour_rollover),
        .day_rollover  (day_rollover)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hour_rollover) hr_cnt++;
        if (day_rollover) day_cnt++;
        if (hour_rollover && day_rollover) both_cnt++;
        if (set_done) done_cnt++;
        if (set_err) err_cnt++;
`ifdef TOD_ALARM_EN
        if (alarm_hit) alarm_cnt++;
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        min_tick = 1'b1;
        step();
        min_tick = 1'b0;
        step();
        step();
    endtask

    task automatic chk_time(input string name, input logic [4:0] eh, input logic [5:0] em);
        checks++;
        if (hours !== eh || minutes !== em) begin
            errors++;
            $display("FAIL %s: got %0d:%0d expected %0d:%0d", name, hours, minutes, eh, em);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!set_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!set_ready) begin
            errors++;
            $display("FAIL %s: set_ready got 0 expected 1 within 20 cycles", name);
        end
    endtask

    // Full handshake: hold valid until done/err, release, wait for ready.
    task automatic do_set(input string name, input logic [4:0] h, input logic [5:0] m);
        int n = 0;
        set_hours   = h;
        set_minutes = m;
        set_valid   = 1'b1;
        step();
        while (!(set_done || set_err) && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (!(set_done || set_err)) begin
            errors++;
            $display("FAIL %s: no set_done/set_err within 10 cycles", name);
        end
        set_valid = 1'b0;
        step();
        wait_ready(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if (minutes !== 6'd0 || hours !== 5'd0 || set_ready !== 1'b1 || set_done !== 1'b0 ||
            set_err !== 1'b0 || hour_rollover !== 1'b0 || day_rollover !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %0d:%0d rdy=%b done=%b err=%b hr=%b day=%b expected 0:0 rdy=1 rest 0",
                     hours, minutes, set_ready, set_done, set_err, hour_rollover, day_rollover);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_hour_count();
        int hr0 = hr_cnt, day0 = day_cnt;
        for (int i = 0; i < 59; i++) tick();
        chk_time("count_59", 5'd0, 6'd59);
        tick();
        chk_time("count_60", 5'd1, 6'd0);
        chk_int("count_hour_rollovers", hr_cnt - hr0, 1);
        chk_int("count_day_rollovers", day_cnt - day0, 0);
    endtask

    task automatic test_day_wrap();
        int hr0 = hr_cnt, day0 = day_cnt, done0 = done_cnt, both0 = both_cnt;
        do_set("set_2359", 5'd23, 6'd59);
        chk_time("load_2359", 5'd23, 6'd59);
        chk_int("load_2359_done", done_cnt - done0, 1);
        chk_int("load_no_rollover", (hr_cnt - hr0) + (day_cnt - day0), 0);
        min_tick = 1'b1;
        step();
        min_tick = 1'b0;
        chk_time("day_wrap_time", 5'd0, 6'd0);
        chk_int("day_wrap_both_high", int'(hour_rollover && day_rollover), 1);
        step();
        chk_int("day_wrap_pulse_end", int'(hour_rollover || day_rollover), 0);
        chk_int("day_wrap_single_pulse", both_cnt - both0, 1);
    endtask

    task automatic test_range();
        int done0, err0;
        tick();
        chk_time("pre_set_time", 5'd0, 6'd1);
        done0 = done_cnt;
        err0  = err_cnt;
        do_set("set_2410", 5'd24, 6'd10);
        chk_int("bad_hours_err", err_cnt - err0, 1);
        chk_int("bad_hours_no_done", done_cnt - done0, 0);
        chk_time("bad_hours_time", 5'd0, 6'd1);
        do_set("set_1260", 5'd12, 6'd60);
        chk_int("bad_minutes_err", err_cnt - err0, 2);
        chk_int("bad_minutes_no_done", done_cnt - done0, 0);
        chk_time("bad_minutes_time", 5'd0, 6'd1);
    endtask

    task automatic test_collision();
        set_hours   = 5'd5;
        set_minutes = 6'd30;
        set_valid   = 1'b1;
        min_tick    = 1'b1;
        step();                 // accept edge, tick must be ignored
        step();                 // LOAD edge, tick must be ignored
        min_tick = 1'b0;
        chk_int("collision_done_pulse", int'(set_done), 1);
        chk_time("collision_time", 5'd5, 6'd30);
        set_valid = 1'b0;
        step();
        wait_ready("collision_ready");
        chk_time("collision_settled", 5'd5, 6'd30);
        tick();
        chk_time("collision_next_tick", 5'd5, 6'd31);
    endtask

    task automatic test_back_to_back();
        int done0 = done_cnt, rdy_seen = 0;
        set_hours   = 5'd7;
        set_minutes = 6'd15;
        set_valid   = 1'b1;
        step();
        step();
        chk_int("hold_first_done", int'(set_done), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (set_ready) rdy_seen++;
        end
        chk_int("hold_ready_low", rdy_seen, 0);
        chk_int("hold_single_load", done_cnt - done0, 1);
        set_valid = 1'b0;
        step();
        chk_int("hold_release_ready", int'(set_ready), 1);
        chk_time("hold_time", 5'd7, 6'd15);
    endtask

    task automatic test_reset_mid_set();
        int done0, err0, hr0, day0;
        set_hours   = 5'd3;
        set_minutes = 6'd3;
        set_valid   = 1'b1;
        step();
        step();
        step();                 // now parked in DONE with valid held
        done0 = done_cnt;
        err0  = err_cnt;
        hr0   = hr_cnt;
        day0  = day_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk_time("midset_reset_time", 5'd0, 6'd0);
        chk_int("midset_reset_ready", int'(set_ready), 1);
        set_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk_int("midset_no_pulses",
                (done_cnt - done0) + (err_cnt - err0) + (hr_cnt - hr0) + (day_cnt - day0), 0);
        chk_int("midset_ready_after", int'(set_ready), 1);
    endtask

`ifdef TOD_ALARM_EN
    task automatic test_alarm();
        int a0;
        alarm_hours   = 5'd0;
        alarm_minutes = 6'd2;
        alarm_wr      = 1'b1;
        step();
        alarm_wr  = 1'b0;
        alarm_arm = 1'b1;
        do_set("alarm_set_0000", 5'd0, 6'd0);
        a0 = alarm_cnt;
        tick();
        tick();
        chk_time("alarm_time", 5'd0, 6'd2);
        chk_int("alarm_armed_hits", alarm_cnt - a0, 1);
        alarm_arm = 1'b0;
        do_set("alarm_reset_0000", 5'd0, 6'd0);
        a0 = alarm_cnt;
        tick();
        tick();
        chk_int("alarm_disarmed_hits", alarm_cnt - a0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_hour_count();
        test_day_wrap();
        test_range();
        test_collision();
        test_back_to_back();
        test_reset_mid_set();
`ifdef TOD_ALARM_EN
        test_alarm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_time_of_day_counter

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Downstream stage of the seconds counter: consumes its one-cycle `rollover` pulse (wired to `min_tick`) and maintains minutes and hours of a 24-hour clock.
- Emits registered hour and day rollover pulses for calendar logic further downstream.
- Provides a host time-set interface (valid/ready request, done/error acknowledge, four-phase release), with range checking on the loaded value.

Parameters:
- MIN_MAX, 59: terminal minutes value; minutes wrap to 0 after it; must be <= 63.
- HOUR_MAX, 23: terminal hours value; hours wrap to 0 after it; must be <= 31.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- min_tick  in  1  one-cycle pulse, advance one minute (seconds counter rollover)
- set_valid  in  1  host requests load; held until set_done or set_err seen
- set_hours  in  5  requested hours, sampled on accept
- set_minutes  in  6  requested minutes, sampled on accept
- set_ready  out  1  block can accept a set request
- set_done  out  1  one-cycle pulse, load applied
- set_err  out  1  one-cycle pulse, load rejected (out of range)
- minutes  out  6  current minutes
- hours  out  5  current hours
- hour_rollover  out  1  one-cycle pulse on minutes wrap
- day_rollover  out  1  one-cycle pulse on hours wrap

Behaviour:
- Reset (async assert, sync-safe deassert):
  - minutes=0, hours=0, all pulses=0.
  - FSM=RUN, set_ready=1, staging registers=0.
- All outputs are registered. Pulses last exactly one cycle and otherwise read 0.
- FSM states:
  - RUN
    - set_ready=1.
    - set_valid=1: capture set_hours/set_minutes into staging, go to LOAD.
  - LOAD
    - set_ready=0. Lasts exactly one cycle.
    - If staged minutes <= MIN_MAX and hours <= HOUR_MAX: write minutes/hours, pulse set_done.
    - Otherwise leave time unchanged and pulse set_err.
    - Go to DONE.
  - DONE
    - set_ready=0.
    - Wait for set_valid=0, then return to RUN (set_ready=1 the following cycle).
    - If set_valid is still high, stay in DONE; it never re-triggers.
- Counting with min_tick=1:
  - In RUN, excluding the accept cycle: minutes+1.
  - If minutes==MIN_MAX: minutes=0, hours+1, hour_rollover=1 next cycle.
  - If additionally hours==HOUR_MAX: hours=0, day_rollover=1 in the same cycle as hour_rollover.
- Tick collisions:
  - min_tick in the accept cycle, in LOAD, or in DONE is discarded; the time never advances while a set is in progress.
  - After a successful load the time equals exactly the loaded value.
  - After a rejected load the time equals the pre-set value; ticks during the set are still lost.
- No rollover pulses ever result from a load, including loading MIN_MAX/HOUR_MAX or 0:00.
- Reset mid-set: the FSM returns to RUN, a pending set is abandoned, and no set_done or set_err is issued.
- Arithmetic is unsigned, compare-and-wrap only; no modular overflow of the physical width is relied on.

Optional Feature:
- Macro TOD_ALARM_EN.
- Defined: adds the following ports.
  - alarm_wr in 1
  - alarm_hours in 5
  - alarm_minutes in 6
  - alarm_arm in 1
  - alarm_hit out 1
- alarm_wr=1 latches alarm_hours/alarm_minutes; reset value is 0:00.
- alarm_hit pulses one cycle when all of the following hold:
  - alarm_arm=1;
  - a min_tick-driven update makes {hours,minutes} equal the alarm value.
- alarm_hit is never raised by a load. It is coincident with the rollover pulses (all registered from the same edge).
- Undefined: alarm ports and logic are absent and the port list is exactly as above.

Decomposition:
- Package tod_pkg:
  - MIN_W=6, HOUR_W=5;
  - FSM state enum {RUN, LOAD, DONE};
  - default MIN_MAX/HOUR_MAX constants.
- Sub-module wrap_counter, parameterised by width and max, instantiated twice (minutes and hours). Interface:
  - inputs: inc, load, load_val;
  - outputs: value, wrap (combinational terminal-and-inc).
- The top level contains the FSM, staging, range check, pulse registers and the optional alarm.

Test Plan:
- Reset then 60 min_tick pulses spaced 3 cycles -> minutes 0, hours 1, exactly one hour_rollover, day_rollover never.
- Load 23:59 (set_valid held until set_done), release, one min_tick -> 00:00, hour_rollover and day_rollover both high in the same single cycle.
- Load 24:10 -> set_err pulse, set_done stays 0, time unchanged from pre-set value; load 12:60 -> set_err likewise.
- min_tick asserted in the accept cycle and in LOAD while loading 05:30 -> time reads 05:30 after set_done, no advance; next RUN tick gives 05:31.
- set_valid held 10 cycles after set_done -> set_ready stays 0, no second load; drop set_valid -> set_ready=1 one cycle later.
- rst_n asserted while in DONE -> 00:00, set_ready=1, no pulses. With TOD_ALARM_EN: alarm 00:02 armed, 2 ticks from 00:00 -> alarm_hit once; disarmed -> none.
